// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings, port ids and line geometry for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int BEAT_W = 32;
  localparam int BEATS  = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - 2-way grant select; MEM_ARB_RR_EN selects round-robin, else D over I
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  input  logic req_d,
  input  logic served_valid,
  input  logic served_port,
  output logic win
);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Reset to PORT_I so the very first tie goes to D, matching the fixed-priority build.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_I;
    end else if (served_valid) begin
      last_q <= served_port;
    end
  end

  always_comb begin
    if (req_i && req_d) begin
      win = ~last_q;
    end else begin
      win = req_d ? PORT_D : PORT_I;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset_n, served_valid, served_port, req_i};

  always_comb begin
    win = req_d ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the 128-bit line memory between I-fetch and data ports
// Arbitration policy chosen by MEM_ARB_RR_EN (round-robin) or fixed D-over-I when undefined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int LINE_W = BEATS * BEAT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_i_req,
  input  logic              req_i_we,
  input  logic [ADDR_W-1:0] req_i_addr,
  input  logic [LINE_W-1:0] req_i_wdata,
  output logic              req_i_done,
  input  logic              req_d_req,
  input  logic              req_d_we,
  input  logic [ADDR_W-1:0] req_d_addr,
  input  logic [LINE_W-1:0] req_d_wdata,
  output logic              req_d_done,
  output logic [LINE_W-1:0] rd_line,
  input  logic              abort,
  input  logic              is_loading_memory_into_core,
  output logic              mem_requested,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  output logic              mem_reset_req,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rd_data,
  output logic              owner
);

  arb_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              win;
  logic              grant;
  logic              resp_ok;

  assign grant   = (state == IDLE) && (req_i_req || req_d_req) &&
                   !is_loading_memory_into_core && mem_ready && !abort;
  assign resp_ok = (state == RESP) && !abort;

  mem_arb_pick u_pick (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req_i_req),
    .req_d        (req_d_req),
    .served_valid (resp_ok),
    .served_port  (owner),
    .win          (win)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= PORT_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_line <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= win;
            we_q    <= (win == PORT_D) ? req_d_we    : req_i_we;
            addr_q  <= (win == PORT_D) ? req_d_addr  : req_i_addr;
            wdata_q <= (win == PORT_D) ? req_d_wdata : req_i_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_ready) state <= DRAIN;
        end
        DRAIN: begin
          if (!we_q) rd_line <= mem_rd_data;
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In WAIT the request follows !mem_ready so a returning ready never starts a second access.
  assign mem_requested = !abort && ((state == ISSUE) || ((state == WAIT) && !mem_ready));
  assign mem_we        = we_q && ((state == ISSUE) || (state == WAIT));
  assign mem_reset_req = abort;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign req_i_done    = resp_ok && (owner == PORT_I);
  assign req_d_done    = resp_ok && (owner == PORT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a line-memory model
module tb_mem_arbiter;
  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_i_req, req_i_we, req_d_req, req_d_we;
  logic [ADDR_W-1:0] req_i_addr, req_d_addr;
  logic [LINE_W-1:0] req_i_wdata, req_d_wdata;
  logic              req_i_done, req_d_done;
  logic [LINE_W-1:0] rd_line;
  logic              abort, is_loading_memory_into_core;
  logic              mem_requested, mem_we, mem_reset_req, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wr_data, mem_rd_data;
  logic              owner;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_i_req(req_i_req), .req_i_we(req_i_we), .req_i_addr(req_i_addr),
    .req_i_wdata(req_i_wdata), .req_i_done(req_i_done),
    .req_d_req(req_d_req), .req_d_we(req_d_we), .req_d_addr(req_d_addr),
    .req_d_wdata(req_d_wdata), .req_d_done(req_d_done),
    .rd_line(rd_line), .abort(abort),
    .is_loading_memory_into_core(is_loading_memory_into_core),
    .mem_requested(mem_requested), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_reset_req(mem_reset_req),
    .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .owner(owner)
  );

  // Line memory: accepts a request while ready, stays busy five cycles, then completes.
  logic [LINE_W-1:0] sram [0:255];
  logic [7:0]        m_addr;
  logic              m_we;
  logic [LINE_W-1:0] m_wdata;
  int                m_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ready   <= 1'b1;
      mem_rd_data <= '0;
      m_cnt       <= 0;
    end else if (mem_reset_req) begin
      mem_ready <= 1'b1;
      m_cnt     <= 0;
    end else if (mem_ready && mem_requested) begin
      mem_ready <= 1'b0;
      m_cnt     <= 4;
      m_addr    <= mem_addr[7:0];
      m_we      <= mem_we;
      m_wdata   <= mem_wr_data;
    end else if (!mem_ready) begin
      if (m_cnt == 0) begin
        mem_ready <= 1'b1;
        if (m_we) sram[m_addr] = m_wdata;
        else      mem_rd_data <= sram[m_addr];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  logic [LINE_W-1:0] ref_mem [0:255];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_i_req = 0; req_i_we = 0; req_i_addr = '0; req_i_wdata = '0;
    req_d_req = 0; req_d_we = 0; req_d_addr = '0; req_d_wdata = '0;
    abort = 0; is_loading_memory_into_core = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(output int cyc, output logic got_i, output logic got_d);
    cyc = 0; got_i = 0; got_d = 0;
    while (cyc < 40 && !got_i && !got_d) begin
      tick();
      cyc++;
      got_i = req_i_done;
      got_d = req_d_done;
    end
  endtask

  task automatic quiet(input int n, output logic seen);
    seen = 0;
    repeat (n) begin
      tick();
      if (req_i_done || req_d_done || mem_requested) seen = 1;
    end
  endtask

  int                cyc;
  logic              gi, gd, seen;
  logic [LINE_W-1:0] wline;
  logic              exp_d;

  // Random-phase transaction records
  logic              pend_i, pend_d, last_srv, win_exp;
  logic              ti_we, td_we;
  logic [7:0]        ti_a, td_a;
  logic [LINE_W-1:0] ti_w, td_w;

  initial begin
    for (int k = 0; k < 256; k++) begin
      sram[k]    = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[k] = sram[k];
    end
    sram[8'h10]    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    ref_mem[8'h10] = sram[8'h10];

    do_reset();
    check("reset_mem_requested", 128'(mem_requested), 128'(0));
    check("reset_mem_we", 128'(mem_we), 128'(0));
    check("reset_rd_line", rd_line, 128'(0));
    check("reset_owner", 128'(owner), 128'(0));
    check("reset_addr", 128'(mem_addr), 128'(0));

    // Uncontended I read: done nine cycles after the request is seen.
    req_i_req = 1; req_i_we = 0; req_i_addr = 20'h00010;
    wait_done(cyc, gi, gd);
    check("t1_latency", 128'(cyc), 128'(9));
    check("t1_done_i", 128'(gi), 128'(1));
    check("t1_done_d", 128'(gd), 128'(0));
    check("t1_rd_line", rd_line, ref_mem[8'h10]);
    req_i_req = 0;
    tick();

    // Contention: D write wins, I read follows right after D's response.
    wline = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    req_d_req = 1; req_d_we = 1; req_d_addr = 20'h00020; req_d_wdata = wline;
    req_i_req = 1; req_i_we = 0; req_i_addr = 20'h00040;
    wait_done(cyc, gi, gd);
    check("t2_first_d", 128'(gd), 128'(1));
    check("t2_first_not_i", 128'(gi), 128'(0));
    check("t2_owner_d", 128'(owner), 128'(1));
    req_d_req = 0;
    req_d_wdata = '0;
    ref_mem[8'h20] = wline;
    wait_done(cyc, gi, gd);
    check("t2_i_latency", 128'(cyc), 128'(10));
    check("t2_i_done", 128'(gi), 128'(1));
    check("t2_i_data", rd_line, ref_mem[8'h40]);
    req_i_addr = 20'h00020;
    tick();
    wait_done(cyc, gi, gd);
    check("t2_readback", rd_line, wline);
    req_i_req = 0;
    tick();

    // Both ports hold requests across four transactions.
    do_reset();
    req_i_req = 1; req_i_addr = 20'h00030;
    req_d_req = 1; req_d_addr = 20'h00031;
    for (int k = 0; k < 4; k++) begin
      wait_done(cyc, gi, gd);
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check($sformatf("t3_order%0d", k), 128'({gi, gd}), 128'({~exp_d, exp_d}));
    end
    req_i_req = 0; req_d_req = 0;
    tick();

    // Abort in WAIT: reset pulse, no done, then a fresh read works.
    req_i_req = 1; req_i_we = 0; req_i_addr = 20'h00040;
    repeat (4) tick();
    abort = 1; req_i_req = 0;
    #1;
    check("t4_reset_req", 128'(mem_reset_req), 128'(1));
    check("t4_requested_low", 128'(mem_requested), 128'(0));
    tick();
    abort = 0;
    #1;
    check("t4_reset_req_drop", 128'(mem_reset_req), 128'(0));
    quiet(12, seen);
    check("t4_no_done", 128'(seen), 128'(0));
    req_i_req = 1; req_i_addr = 20'h00020;
    wait_done(cyc, gi, gd);
    check("t4_fresh_latency", 128'(cyc), 128'(9));
    check("t4_fresh_data", rd_line, ref_mem[8'h20]);
    req_i_req = 0;
    tick();

    // Loader owns the SRAM: no grants until it lets go.
    is_loading_memory_into_core = 1;
    req_i_req = 1; req_i_addr = 20'h00010;
    seen = 0;
    repeat (20) begin
      tick();
      if (mem_requested) seen = 1;
    end
    check("t5_blocked", 128'(seen), 128'(0));
    is_loading_memory_into_core = 0;
    #1;
    check("t5_same_cycle", 128'(mem_requested), 128'(0));
    tick();
    check("t5_grant", 128'(mem_requested), 128'(1));
    wait_done(cyc, gi, gd);
    check("t5_latency", 128'(cyc), 128'(8));
    check("t5_data", rd_line, ref_mem[8'h10]);
    req_i_req = 0;
    tick();

    // Asynchronous reset mid-WAIT on a D read.
    req_d_req = 1; req_d_we = 0; req_d_addr = 20'h00040;
    repeat (4) tick();
    check("t6_pre_requested", 128'(mem_requested), 128'(1));
    #2;
    reset_n = 0;
    #1;
    check("t6_requested", 128'(mem_requested), 128'(0));
    check("t6_owner", 128'(owner), 128'(0));
    check("t6_rd_line", rd_line, 128'(0));
    check("t6_addr", 128'(mem_addr), 128'(0));
    check("t6_done", 128'({req_i_done, req_d_done}), 128'(0));
    req_d_req = 0;
    tick();
    reset_n = 1;
    quiet(12, seen);
    check("t6_no_done", 128'(seen), 128'(0));

    // Randomized traffic against the arbitration/memory rules.
    do_reset();
    pend_i = 0; pend_d = 0; last_srv = 1'b0;
    ti_we = 0; td_we = 0; ti_a = 0; td_a = 0; ti_w = 0; td_w = 0;
    for (int n = 0; n < 40; n++) begin
      if (!pend_i && ($urandom_range(1, 0) == 1)) begin
        pend_i = 1; ti_we = 1'($urandom_range(1, 0)); ti_a = 8'($urandom_range(255, 0));
        ti_w = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!pend_d && ($urandom_range(1, 0) == 1)) begin
        pend_d = 1; td_we = 1'($urandom_range(1, 0)); td_a = 8'($urandom_range(255, 0));
        td_w = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1; ti_we = 0; ti_a = 8'($urandom_range(255, 0)); ti_w = '0;
      end
      req_i_req = pend_i; req_i_we = ti_we; req_i_addr = {12'h0, ti_a}; req_i_wdata = ti_w;
      req_d_req = pend_d; req_d_we = td_we; req_d_addr = {12'h0, td_a}; req_d_wdata = td_w;
`ifdef MEM_ARB_RR_EN
      win_exp = (pend_i && pend_d) ? ~last_srv : pend_d;
`else
      win_exp = pend_d;
`endif
      wait_done(cyc, gi, gd);
      check($sformatf("rnd%0d_winner", n), 128'({gi, gd}), 128'({~win_exp, win_exp}));
      check($sformatf("rnd%0d_owner", n), 128'(owner), 128'(win_exp));
      if (win_exp) begin
        if (td_we) ref_mem[td_a] = td_w;
        else check($sformatf("rnd%0d_rd_d", n), rd_line, ref_mem[td_a]);
        pend_d = 0; req_d_req = 0;
      end else begin
        if (ti_we) ref_mem[ti_a] = ti_w;
        else check($sformatf("rnd%0d_rd_i", n), rd_line, ref_mem[ti_a]);
        pend_i = 0; req_i_req = 0;
      end
      last_srv = win_exp;
    end
    req_i_req = 0; req_d_req = 0;
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
